// File: rtl/up_copy_ctrl.sv
// Word-granular memory-to-memory copy engine: reads up to BUF_DEPTH words, then writes them out, repeating until done.
// Optional build macro UP_COPY_ALIGN_CHECK_EN rejects misaligned src/dst with a sticky err_o instead of truncating.
module up_copy_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 16,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [SIZE_WIDTH-1:0] size_i,
    input  logic                  ctrl_int_en_i,
    input  logic                  cmd_trigger_pulse_i,
    input  logic                  cmd_clr_int_pulse_i,
    output logic                  status_busy_o,
    output logic                  status_int_pending_o,
    output logic                  irq_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [SIZE_WIDTH-1:0] r_rd_left;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_int_pending;

    logic                  w_trig;
    logic                  w_misalign;
    logic                  w_push;
    logic                  w_pop;
    logic [SIZE_WIDTH-1:0] w_words;
    logic [CNT_W-1:0]      w_cnt_inc;

    assign w_trig    = (r_state == IDLE) && cmd_trigger_pulse_i;
    assign w_push    = (r_state == RWAIT) && mem_rvalid_i;
    assign w_pop     = (r_state == WRITE) && mem_gnt_i;
    assign w_words   = size_i >> 2;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef UP_COPY_ALIGN_CHECK_EN
    logic r_err;
    assign w_misalign = (|src_addr_i[1:0]) | (|dst_addr_i[1:0]);
    assign err_o      = r_err;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_err <= 1'b0;
        end else if (w_trig) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_next = (w_misalign || (w_words == '0)) ? DONE : READ;
                end
            end
            READ: begin
                if (mem_gnt_i) w_next = RWAIT;
            end
            RWAIT: begin
                // r_rd_left still counts the word being received this cycle
                if (mem_rvalid_i) begin
                    w_next = ((w_cnt_inc != FULL) && (r_rd_left != SIZE_WIDTH'(1))) ? READ : WRITE;
                end
            end
            WRITE: begin
                if (mem_gnt_i && (r_cnt == CNT_W'(1))) begin
                    w_next = (r_rd_left != '0) ? READ : DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_left     <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_cnt         <= '0;
            r_int_pending <= 1'b0;
        end else begin
            if (w_trig) begin
                r_rd_left <= w_words;
            end else if (w_push) begin
                r_rd_left <= r_rd_left - SIZE_WIDTH'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
                r_cnt  <= w_cnt_inc;
            end else if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            // Setting in DONE takes priority over a coincident clear
            if ((r_state == DONE) && ctrl_int_en_i) begin
                r_int_pending <= 1'b1;
            end else if (cmd_clr_int_pulse_i) begin
                r_int_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_trig) begin
            r_src <= src_addr_i & ~ADDR_WIDTH'(3);
            r_dst <= dst_addr_i & ~ADDR_WIDTH'(3);
        end else begin
            if (w_push) r_src <= r_src + WORD_STEP;
            if (w_pop)  r_dst <= r_dst + WORD_STEP;
        end
        if (w_push) begin
            r_buf[r_wptr] <= mem_rdata_i;
        end
    end

    assign mem_req_o            = (r_state == READ) || (r_state == WRITE);
    assign mem_we_o             = (r_state == WRITE);
    assign mem_addr_o           = (r_state == READ)  ? r_src :
                                  (r_state == WRITE) ? r_dst : '0;
    assign mem_wdata_o          = (r_state == WRITE) ? r_buf[r_rptr] : '0;
    assign mem_be_o             = (r_state == WRITE) ? 4'hF : 4'h0;
    assign status_busy_o        = (r_state != IDLE);
    assign status_int_pending_o = r_int_pending;
    assign irq_o                = r_int_pending;
endmodule

// File: tb/tb_up_copy_ctrl.sv
// Directed bench for up_copy_ctrl with a simple memory responder (read data = 0xA5000000 ^ address).
module tb_up_copy_ctrl;
    logic        ACLK;
    logic        ARESET;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] size_i;
    logic        ctrl_int_en_i;
    logic        cmd_trigger_pulse_i;
    logic        cmd_clr_int_pulse_i;
    logic        status_busy_o;
    logic        status_int_pending_o;
    logic        irq_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        gnt_en;
    logic        auto_rv;
    logic        rv_auto;
    logic        rv_man;
    logic [31:0] rdata_q;
    logic [31:0] rdata_man;
    logic [31:0] dmem [0:4095];
    logic [31:0] last_waddr;
    logic [63:0] hs_log;
    int          n_rd;
    int          n_wr;
    int          n_req;
    int          n_tests;
    int          n_fail;

    up_copy_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SIZE_WIDTH(16), .BUF_DEPTH(4)
    ) dut (
        .ACLK                 (ACLK),
        .ARESET               (ARESET),
        .src_addr_i           (src_addr_i),
        .dst_addr_i           (dst_addr_i),
        .size_i               (size_i),
        .ctrl_int_en_i        (ctrl_int_en_i),
        .cmd_trigger_pulse_i  (cmd_trigger_pulse_i),
        .cmd_clr_int_pulse_i  (cmd_clr_int_pulse_i),
        .status_busy_o        (status_busy_o),
        .status_int_pending_o (status_int_pending_o),
        .irq_o                (irq_o),
        .err_o                (err_o),
        .mem_req_o            (mem_req_o),
        .mem_we_o             (mem_we_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_be_o             (mem_be_o),
        .mem_gnt_i            (mem_gnt_i),
        .mem_rvalid_i         (mem_rvalid_i),
        .mem_rdata_i          (mem_rdata_i)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    assign mem_gnt_i    = mem_req_o & gnt_en;
    assign mem_rvalid_i = rv_auto | rv_man;
    assign mem_rdata_i  = rv_man ? rdata_man : rdata_q;

    // Memory responder: grant combinational, read data returned one cycle after grant
    always @(posedge ACLK) begin
        rv_auto <= 1'b0;
        if (mem_req_o) n_req <= n_req + 1;
        if (mem_req_o && mem_gnt_i) begin
            hs_log <= {hs_log[62:0], mem_we_o};
            if (mem_we_o) begin
                dmem[mem_addr_o[13:2]] <= mem_wdata_o;
                last_waddr <= mem_addr_o;
                n_wr <= n_wr + 1;
            end else begin
                rv_auto <= auto_rv;
                rdata_q <= 32'hA500_0000 ^ mem_addr_o;
                n_rd <= n_rd + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sz, input logic en);
        @(negedge ACLK);
        src_addr_i          = s;
        dst_addr_i          = d;
        size_i              = sz;
        ctrl_int_en_i       = en;
        cmd_trigger_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_trigger_pulse_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (status_busy_o && c < maxc) begin
            @(negedge ACLK);
            c++;
        end
        check("idle_timeout", status_busy_o, 1'b0);
    endtask

    task automatic clr_int();
        @(negedge ACLK);
        cmd_clr_int_pulse_i = 1'b1;
        @(negedge ACLK);
        cmd_clr_int_pulse_i = 1'b0;
    endtask

    initial begin
        int rd0, wr0, req0, bad, c;
        n_tests = 0; n_fail = 0;
        n_rd = 0; n_wr = 0; n_req = 0;
        hs_log = '0; last_waddr = '0; rv_auto = 1'b0; rdata_q = '0;
        ARESET = 1'b1;
        src_addr_i = '0; dst_addr_i = '0; size_i = '0; ctrl_int_en_i = 1'b0;
        cmd_trigger_pulse_i = 1'b0; cmd_clr_int_pulse_i = 1'b0;
        gnt_en = 1'b1; auto_rv = 1'b1; rv_man = 1'b0; rdata_man = '0;
        repeat (3) @(negedge ACLK);

        check("rst_req", mem_req_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_be", mem_be_o, 4'h0);
        check("rst_busy", status_busy_o, 1'b0);
        check("rst_int", status_int_pending_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        ARESET = 1'b0;

        // Basic 4-word copy
        rd0 = n_rd; wr0 = n_wr;
        start(32'h1000, 32'h2000, 16'd16, 1'b1);
        check("t1_busy", status_busy_o, 1'b1);
        check("t1_first_req", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 32'h1000});
        wait_idle(200);
        check("t1_reads", n_rd - rd0, 4);
        check("t1_writes", n_wr - wr0, 4);
        for (int i = 0; i < 4; i++)
            check("t1_data", dmem[(32'h2000 + 4 * i) >> 2 & 12'hFFF], 32'hA500_0000 ^ (32'h1000 + 4 * i));
        check("t1_int", status_int_pending_o, 1'b1);
        check("t1_irq", irq_o, 1'b1);
        clr_int();
        check("t1_clr", status_int_pending_o, 1'b0);

        // 10 words through a 4-deep buffer
        wr0 = n_wr;
        start(32'h1000, 32'h2000, 16'd40, 1'b0);
        c = 0;
        while ((n_wr - wr0) < 10 && c < 300) begin
            @(negedge ACLK);
            c++;
        end
        check("t2_writes", n_wr - wr0, 10);
        check("t2_busy_done", status_busy_o, 1'b1);
        @(negedge ACLK);
        check("t2_busy_drop", status_busy_o, 1'b0);
        check("t2_phases", hs_log[19:0], 20'h0F0F3);
        check("t2_last_addr", last_waddr, 32'h2024);
        check("t2_last_data", dmem[12'h809], 32'hA500_1024);
        check("t2_int_off", status_int_pending_o, 1'b0);

        // Zero-word copies: size 0 without int, size 3 with int
        req0 = n_req;
        start(32'h1000, 32'h2000, 16'd0, 1'b0);
        check("t3_busy_pulse", status_busy_o, 1'b1);
        @(negedge ACLK);
        check("t3_busy_end", status_busy_o, 1'b0);
        check("t3_int0", status_int_pending_o, 1'b0);
        start(32'h1000, 32'h2000, 16'd3, 1'b1);
        check("t3b_busy_pulse", status_busy_o, 1'b1);
        @(negedge ACLK);
        check("t3b_busy_end", status_busy_o, 1'b0);
        check("t3b_int1", status_int_pending_o, 1'b1);
        check("t3_no_req", n_req - req0, 0);
        clr_int();

        // Grant stalled 5 cycles with a retrigger while busy
        gnt_en = 1'b0;
        rd0 = n_rd; wr0 = n_wr;
        start(32'h1000, 32'h2200, 16'd8, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!mem_req_o || mem_we_o || mem_addr_o != 32'h1000 || mem_be_o != 4'h0) bad++;
            if (i == 1) begin
                src_addr_i = 32'h3000;
                cmd_trigger_pulse_i = 1'b1;
            end else begin
                cmd_trigger_pulse_i = 1'b0;
            end
            @(negedge ACLK);
        end
        check("t4_stable", bad, 0);
        gnt_en = 1'b1;
        wait_idle(200);
        check("t4_reads", n_rd - rd0, 2);
        check("t4_writes", n_wr - wr0, 2);
        check("t4_data0", dmem[12'h880], 32'hA500_1000);
        check("t4_data1", dmem[12'h881], 32'hA500_1004);
        req0 = n_req;
        repeat (5) @(negedge ACLK);
        check("t4_once", n_req - req0, 0);

        // Clear pulse in the DONE cycle loses; one cycle later it wins
        start(32'h1000, 32'h2000, 16'd0, 1'b1);
        cmd_clr_int_pulse_i = 1'b1;
        @(negedge ACLK);
        check("t5_set_wins", status_int_pending_o, 1'b1);
        @(negedge ACLK);
        cmd_clr_int_pulse_i = 1'b0;
        check("t5_clear", status_int_pending_o, 1'b0);

        // Reset during RWAIT, then a late rvalid
        auto_rv = 1'b0;
        wr0 = n_wr;
        start(32'h1000, 32'h2300, 16'd4, 1'b1);
        @(negedge ACLK);
        check("t6_rwait_noreq", mem_req_o, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        rv_man = 1'b1;
        rdata_man = 32'hDEAD_BEEF;
        @(negedge ACLK);
        rv_man = 1'b0;
        check("t6_busy", status_busy_o, 1'b0);
        check("t6_outs", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, err_o, irq_o}, 40'h0);
        repeat (3) @(negedge ACLK);
        check("t6_no_write", n_wr - wr0, 0);
        auto_rv = 1'b1;
        start(32'h1040, 32'h2300, 16'd4, 1'b0);
        wait_idle(100);
        check("t6_fresh_data", dmem[12'h8C0], 32'hA500_1040);

`ifdef UP_COPY_ALIGN_CHECK_EN
        req0 = n_req;
        start(32'h1002, 32'h2400, 16'd8, 1'b1);
        check("t7_busy", status_busy_o, 1'b1);
        check("t7_err", err_o, 1'b1);
        @(negedge ACLK);
        check("t7_no_req", n_req - req0, 0);
        check("t7_int", status_int_pending_o, 1'b1);
        check("t7_err_sticky", err_o, 1'b1);
        start(32'h1000, 32'h2400, 16'd4, 1'b0);
        check("t7_err_clr", err_o, 1'b0);
        wait_idle(100);
        check("t7_data", dmem[12'h900], 32'hA500_1000);
        clr_int();
`else
        start(32'h1002, 32'h2402, 16'd4, 1'b0);
        check("t7_read_addr", mem_addr_o, 32'h1000);
        wait_idle(100);
        check("t7_waddr", last_waddr, 32'h2400);
        check("t7_data", dmem[12'h900], 32'hA500_1000);
        check("t7_err", err_o, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/up_copy_ctrl.md
UP_COPY_CTRL -- requirements
Module: up_copy_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width; only 32 is supported.
REQ-003 SHALL have parameter SIZE_WIDTH, default 16, width of the byte-count register.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, depth of the word buffer in words; power of two, 2..16.
REQ-005 SHALL have ports ACLK input 1 (the single clock) and ARESET input 1 (synchronous, active-high reset), listed first.
REQ-006 SHALL have ports src_addr_i, dst_addr_i input ADDR_WIDTH, source and destination byte addresses from the register file.
REQ-007 SHALL have ports size_i input SIZE_WIDTH (byte count), ctrl_int_en_i input 1, cmd_trigger_pulse_i input 1 and cmd_clr_int_pulse_i input 1.
REQ-008 SHALL have ports status_busy_o output 1, status_int_pending_o output 1, irq_o output 1 and err_o output 1.
REQ-009 SHALL have master port mem_req_o output 1, mem_we_o output 1, mem_addr_o output ADDR_WIDTH, mem_wdata_o output DATA_WIDTH and mem_be_o output 4.
REQ-010 SHALL have memory inputs mem_gnt_i 1, mem_rvalid_i 1 and mem_rdata_i DATA_WIDTH.

Function
REQ-011 SHALL implement states IDLE, READ, RWAIT, WRITE and DONE.
REQ-012 SHALL, in IDLE on cmd_trigger_pulse_i, latch src, dst and word count = size_i >> 2 (low two bits ignored) and enter READ; status_busy_o = 1 from the next cycle.
REQ-013 SHALL ignore cmd_trigger_pulse_i in every state except IDLE.
REQ-014 SHALL, on trigger with word count 0, go directly to DONE with no memory access.
REQ-015 SHALL, in READ, assert mem_req_o with mem_we_o = 0 at the current source address; move to RWAIT on the cycle mem_gnt_i = 1.
REQ-016 SHALL hold mem_addr_o, mem_we_o, mem_wdata_o and mem_be_o stable while mem_req_o = 1 and mem_gnt_i = 0.
REQ-017 SHALL keep at most one read outstanding; in RWAIT, push mem_rdata_i into the buffer on mem_rvalid_i and add 4 to the source address.
REQ-018 SHALL, after each RWAIT completion, return to READ while the buffer is not full and reads remain; otherwise enter WRITE.
REQ-019 SHALL, in WRITE, assert mem_req_o, mem_we_o = 1, mem_be_o = 4'hF with the buffer head; pop the head and add 4 to the destination address on mem_gnt_i.
REQ-020 SHALL, when the buffer empties in WRITE, enter READ if reads remain, else DONE.
REQ-021 SHALL write words in the order they were read; buffer full/empty uses a log2(BUF_DEPTH)+1-bit count; pointers wrap modulo BUF_DEPTH.
REQ-022 SHALL, in DONE, set status_int_pending_o if ctrl_int_en_i = 1 and return to IDLE next cycle; status_busy_o = 0 in IDLE.
REQ-023 SHALL clear status_int_pending_o on cmd_clr_int_pulse_i; a simultaneous set in DONE wins over the clear.
REQ-024 SHALL drive irq_o = status_int_pending_o.
REQ-025 SHALL wrap address arithmetic modulo 2^ADDR_WIDTH.
REQ-026 SHALL drive mem_req_o = 0 in IDLE, DONE and RWAIT.

Reset
REQ-027 SHALL, on ARESET = 1 at a rising ACLK edge in any state, enter IDLE, discard buffer contents and outstanding reads, and drive all outputs to 0.
REQ-028 SHALL ignore mem_rvalid_i arriving after a reset that aborted RWAIT.

Configuration
REQ-029 SHALL, with macro UP_COPY_ALIGN_CHECK_EN defined, on trigger with src or dst low two bits nonzero, perform no access, set err_o sticky, go to DONE (int_pending rule unchanged); the next accepted trigger clears err_o.
REQ-030 SHALL, without UP_COPY_ALIGN_CHECK_EN, force the low two address bits to 0 and tie err_o to 0.

Verification
REQ-031 SHALL cover: src 0x1000, dst 0x2000, size 16, int_en 1, gnt same cycle, rvalid 1 cycle later -> 4 reads then 4 writes, data matches, int_pending and irq = 1.
REQ-032 SHALL cover: size 40 with BUF_DEPTH 4 -> read/write phases 4,4,2 words; final dst address written 0x2024; busy drops after last write.
REQ-033 SHALL cover: size 0 or size 3 -> no mem_req_o, busy pulses for DONE, int_pending set only if int_en = 1.
REQ-034 SHALL cover: gnt stalled 5 cycles, second trigger while busy -> request held stable, trigger ignored, copy completes once.
REQ-035 SHALL cover: clr_int pulse in the DONE cycle -> int_pending = 1; clr_int one cycle later -> int_pending = 0.
REQ-036 SHALL cover: ARESET asserted in RWAIT, late rvalid -> IDLE, outputs 0, no buffer write; with macro, src 0x1002 -> err_o = 1, no access.
